// File: rtl/bus_txn_arbiter.sv
// Four-master round-robin bus arbiter with access tracking, owner lock and one dead cycle per handover.
// Optional hold limit (forced handover after HOLD_MAX contended cycles) is enabled by BUS_ARB_HOLD_LIMIT_EN.
module bus_txn_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req_n_i,
  input  logic [3:0] m_lock_n_i,
  input  logic       bus_as_n_i,
  input  logic       bus_rdy_n_i,
  output logic [3:0] m_grnt_n_o,
  output logic [1:0] owner_o,
  output logic       arb_busy_o,
  output logic       hold_expire_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    HANDOVER = 2'd2
  } state_e;

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX > (2 ** HOLD_W) - 1) begin : gBadCfg
    $error("bus_txn_arbiter: HOLD_MAX must be 1..255 and fit in HOLD_W bits");
  end

  state_e     state_q;
  logic [1:0] owner_q;
  logic [1:0] next_q;
  logic [3:0] grant_q;
  logic       busy_q;

  logic [1:0] nextOwner_d;
  logic [1:0] cand;
  logic       ownerReq;
  logic       ownerLock;
  logic       otherReq;
  logic       forceDue;
  logic       handoverGo;

  assign ownerReq  = !m_req_n_i[owner_q];
  assign ownerLock = !m_lock_n_i[owner_q];

  // Nearest requester after the owner wins, so scan from the far end and let closer hits overwrite.
  always_comb begin
    nextOwner_d = owner_q;
    otherReq    = 1'b0;
    cand        = owner_q;
    for (int k = 3; k >= 1; k--) begin
      cand = owner_q + 2'(k);
      if (!m_req_n_i[cand]) begin
        nextOwner_d = cand;
        otherReq    = 1'b1;
      end
    end
  end

`ifdef BUS_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] holdCnt_q;
  logic [HOLD_W-1:0] holdCnt_d;
  logic              expire_q;
  logic              contended;

  assign contended = ownerReq && otherReq && !ownerLock;
  assign forceDue  = (holdCnt_q == HOLD_W'(HOLD_MAX));

  always_comb begin
    holdCnt_d = '0;
    if (state_q != HANDOVER && contended) begin
      holdCnt_d = forceDue ? holdCnt_q : holdCnt_q + 1'b1;
    end
  end

  assign hold_expire_o = expire_q;
`else
  assign forceDue      = 1'b0;
  assign hold_expire_o = 1'b0;
`endif

  // Handover is only considered between accesses; a zero-wait or starting access always wins.
  assign handoverGo = bus_as_n_i && !ownerLock && otherReq && (!ownerReq || forceDue);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      next_q  <= 2'd0;
      grant_q <= 4'b1110;
      busy_q  <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      holdCnt_q <= '0;
      expire_q  <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
      holdCnt_q <= holdCnt_d;
      expire_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (!bus_as_n_i && bus_rdy_n_i) begin
            state_q <= ACCESS;
            busy_q  <= 1'b1;
          end else if (handoverGo) begin
            state_q <= HANDOVER;
            grant_q <= 4'b1111;
            next_q  <= nextOwner_d;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            holdCnt_q <= '0;
            expire_q  <= ownerReq;
`endif
          end
        end
        ACCESS: begin
          if (!bus_rdy_n_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HANDOVER: begin
          state_q <= IDLE;
          owner_q <= next_q;
          grant_q <= ~(4'b0001 << next_q);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_grnt_n_o = grant_q;
  assign owner_o    = owner_q;
  assign arb_busy_o = busy_q;

endmodule

// File: doc/bus_txn_arbiter.md
# bus_txn_arbiter

Transaction-aware four-master bus arbiter for the shared system bus. It grants one master at a time in round-robin order and never moves ownership while an access is outstanding. It inserts one dead cycle on every ownership change and supports a per-master bus lock. An optional hold limit stops one master from monopolising the bus. It sits between the bus masters and the bus master multiplexer, and drives the mux select through `owner`.

## Interface
- HOLD_MAX, 16: contended-cycle limit before forced handover (1..255)
- HOLD_W, 8: hold counter width; must hold HOLD_MAX
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- m_req_  in  4  bus request per master, active-low, bit i = master i
- m_lock_  in  4  bus lock per master, active-low; honoured only for current owner
- bus_as_  in  1  address strobe of granted master, active-low, one cycle per access start
- bus_rdy_  in  1  slave ready, active-low, marks access completion
- m_grnt_  out  4  bus grant per master, active-low, registered, at most one low
- owner  out  2  current owner index (mux select), registered
- arb_busy  out  1  high while an access is outstanding (ACCESS state)
- hold_expire  out  1  one-cycle pulse on forced handover

## Operation
- States: IDLE (owner granted, no access outstanding), ACCESS (access started, awaiting rdy_), HANDOVER (all grants high, next owner latched).
- IDLE → ACCESS: bus_as_ low and bus_rdy_ high. If bus_as_ and bus_rdy_ are both low in the same cycle, the access is zero-wait and the arbiter stays in IDLE.
- ACCESS → IDLE: bus_rdy_ low. No ownership decision is made in ACCESS.
- IDLE → HANDOVER requires all of the following:
  - bus_as_ high.
  - Owner lock_ high.
  - At least one non-owner req_ low.
  - Either the owner's req_ is high, or a forced handover is due (see Configuration).
- Next owner is the first master with req_ low, scanning owner+1, owner+2, owner+3 mod 4.
- HANDOVER → IDLE after exactly one cycle. owner and grant are updated to the latched master even if that master has since dropped req_.
- Parking: with no other request, the owner keeps its grant even if its own req_ is high.
- Lock: owner lock_ low blocks every handover and clears the hold counter. A non-owner's lock_ is ignored.
- Reset values:
  - State IDLE, owner 0, m_grnt_ 4'b1110 (master 0 parked).
  - arb_busy 0, hold_expire 0, hold counter 0.
- Reset mid-access drops the outstanding access; there is no completion tracking across reset.

## Timing
- Request to grant:
  - Non-owner req_ sampled low at edge N with the owner released → HANDOVER from N.
  - All grants are high in cycle N..N+1.
  - New grant is low and owner is updated from edge N+1.
  - Grant latency is 2 edges.
- Owner req_ high, bus_as_ low in the same IDLE cycle: the access wins and the handover is re-evaluated after completion.
- arb_busy rises at the edge entering ACCESS and falls at the edge bus_rdy_ is sampled low.
- Grant is never withdrawn in IDLE or ACCESS except via HANDOVER.
- Simultaneous requests from all three non-owners: the nearest in rotation wins; the others wait at least one more full handover.

## Configuration
- BUS_ARB_HOLD_LIMIT_EN defined:
  - The hold counter increments each cycle (IDLE or ACCESS) in which all of the following hold: owner req_ low, any non-owner req_ low, owner lock_ high.
  - It saturates at HOLD_MAX, clears on HANDOVER, and clears on any cycle without that contention.
  - In IDLE with counter == HOLD_MAX and bus_as_ high, the arbiter forces HANDOVER although the owner still requests.
  - hold_expire pulses on the edge entering HANDOVER.
- BUS_ARB_HOLD_LIMIT_EN undefined:
  - No hold counter.
  - Ownership is purely request-driven; the owner keeps the bus while its req_ is low.
  - hold_expire is tied 0.

## Test plan
- Reset with all req_ high → m_grnt_ 4'b1110, owner 0, arb_busy 0. Hold for 10 cycles: no change.
- Master 0 releases and masters 1 and 3 req_ low at edge 0 → grants 4'b1111 after edge 0, 4'b1101 and owner 1 after edge 1. Master 1 releases → master 3 granted 2 edges later.
- Owner 2 asserts bus_as_ with bus_rdy_ delayed 3 cycles while master 0 requests and owner 2 drops req_ → arb_busy high 3 cycles. HANDOVER only after bus_rdy_ low; master 0 granted 2 edges after completion.
- Owner 1 lock_ low, req_ low, master 2 requesting for 40 cycles → grant stays 4'b1101, hold_expire never pulses. Release lock_ → master 2 granted only once master 1 drops req_ (macro off) or after HOLD_MAX=16 further contended cycles (macro on).
- Macro on, HOLD_MAX=4, owner 0 and master 3 requesting continuously → hold_expire pulses after the 4th contended cycle, master 3 granted next edge. Then master 0 regains the bus 4 contended cycles later.
- Assert reset during ACCESS with owner 3 → next cycle m_grnt_ 4'b1110, owner 0, arb_busy 0. A late bus_rdy_ is ignored.
